// File: rtl/csr_ctrl.sv
// Machine-mode CSR sequencer: two-cycle Zicsr read-modify-write, trap entry and MRET.
// Owns mscratch/mstatus/mcause/mtvec/mepc/cycle and exports them to the read decoder.
module csr_ctrl #(
  parameter int unsigned N    = 64,
  parameter int unsigned NCSR = 6
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      csr_req,
  input  logic [2:0]                csr_op,
  input  logic [11:0]               csr_addr,
  input  logic [N-1:0]              csr_wdata,
  input  logic [4:0]                csr_zimm,
  input  logic                      csr_src_zero,
  output logic [11:0]               csr_addr_q,
  input  logic [N-1:0]              csr_read,
  output logic [NCSR-1:0][N-1:0]    csr_out,
  output logic [N-1:0]              csr_rdata,
  output logic                      csr_done,
  output logic                      csr_illegal,
  input  logic                      trap_req,
  input  logic [N-1:0]              trap_cause,
  input  logic [N-1:0]              trap_pc,
  input  logic                      mret_req,
  output logic                      redirect_valid,
  output logic [N-1:0]              redirect_pc,
  output logic                      busy
);

  localparam logic [N-1:0] MstatusFixed = 'h1800;
  localparam logic [N-1:0] MstatusWmask = 'h88;
  localparam logic [N-1:0] Low2Mask     = 'h3;
  localparam logic [N-1:0] Bit1Mask     = 'h2;
  localparam logic [N-1:0] One          = 'h1;

  typedef enum logic [2:0] {StIdle, StRd, StWr, StTrap, StMret} state_e;

  state_e       state_q;
  logic [1:0]   op_q;
  logic [N-1:0] src_q, old_q, tcause_q, tpc_q;
  logic         srczero_q;
  logic [N-1:0] mscratch_q, mstatus_q, mcause_q, mtvec_q, mepc_q, cycle_q;

  logic         addr_ok, addr_ro, wr_req, illegal;
  logic [N-1:0] new_val, trap_target;

  assign csr_out[0] = mscratch_q;
  assign csr_out[1] = mstatus_q;
  assign csr_out[2] = mcause_q;
  assign csr_out[3] = mtvec_q;
  assign csr_out[4] = mepc_q;
  assign csr_out[5] = cycle_q;
  assign busy       = (state_q != StIdle);

  always_comb begin
    addr_ok = 1'b0;
    addr_ro = 1'b0;
    case (csr_addr_q)
      12'h300, 12'h305, 12'h340, 12'h341, 12'h342: addr_ok = 1'b1;
      12'h301, 12'hC00, 12'hF11, 12'hF12, 12'hF13, 12'hF14: begin
        addr_ok = 1'b1;
        addr_ro = 1'b1;
      end
      default: ;
    endcase
    // RW forms always write; RS/RC only when the source register/uimm is nonzero.
    wr_req  = (op_q == 2'b01) || !srczero_q;
    illegal = !addr_ok || (op_q == 2'b00) || (addr_ro && wr_req);
    case (op_q)
      2'b01:   new_val = src_q;
      2'b10:   new_val = old_q | src_q;
      2'b11:   new_val = old_q & ~src_q;
      default: new_val = old_q;
    endcase
    trap_target = mtvec_q & ~Low2Mask;
    if (mtvec_q[0] && tcause_q[N-1]) trap_target = trap_target + {tcause_q[N-3:0], 2'b00};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= StIdle;
      csr_addr_q     <= '0;
      op_q           <= '0;
      src_q          <= '0;
      srczero_q      <= 1'b0;
      old_q          <= '0;
      tcause_q       <= '0;
      tpc_q          <= '0;
      csr_rdata      <= '0;
      csr_done       <= 1'b0;
      csr_illegal    <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      mscratch_q     <= '0;
      mstatus_q      <= MstatusFixed;
      mcause_q       <= '0;
      mtvec_q        <= '0;
      mepc_q         <= '0;
      cycle_q        <= '0;
    end else begin
      cycle_q        <= cycle_q + One;
      csr_done       <= 1'b0;
      csr_illegal    <= 1'b0;
      redirect_valid <= 1'b0;
      case (state_q)
        StIdle: begin
          if (trap_req) begin
            tcause_q <= trap_cause;
            tpc_q    <= trap_pc;
            state_q  <= StTrap;
          end else if (mret_req) begin
            state_q <= StMret;
          end else if (csr_req) begin
            csr_addr_q <= csr_addr;
            op_q       <= csr_op[1:0];
            src_q      <= csr_op[2] ? {{(N-5){1'b0}}, csr_zimm} : csr_wdata;
            srczero_q  <= csr_src_zero;
            state_q    <= StRd;
          end
        end
        StRd: begin
          old_q   <= csr_read;
          state_q <= StWr;
        end
        StWr: begin
          csr_done    <= 1'b1;
          csr_illegal <= illegal;
          csr_rdata   <= illegal ? '0 : old_q;
          if (!illegal && wr_req) begin
            case (csr_addr_q)
              12'h300: mstatus_q  <= (new_val & MstatusWmask) | MstatusFixed;
              12'h305: mtvec_q    <= new_val & ~Bit1Mask;
              12'h340: mscratch_q <= new_val;
              12'h341: mepc_q     <= new_val & ~Low2Mask;
              12'h342: mcause_q   <= new_val;
              default: ;
            endcase
          end
          state_q <= StIdle;
        end
        StTrap: begin
          mepc_q         <= tpc_q & ~Low2Mask;
          mcause_q       <= tcause_q;
          // MPIE <= MIE, MIE <= 0
          mstatus_q      <= {mstatus_q[N-1:8], mstatus_q[3], mstatus_q[6:4], 1'b0,
                             mstatus_q[2:0]};
          redirect_valid <= 1'b1;
          redirect_pc    <= trap_target;
          state_q        <= StIdle;
        end
        StMret: begin
          // MIE <= MPIE, MPIE <= 1
          mstatus_q      <= {mstatus_q[N-1:8], 1'b1, mstatus_q[6:4], mstatus_q[7],
                             mstatus_q[2:0]};
          redirect_valid <= 1'b1;
          redirect_pc    <= mepc_q;
          state_q        <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_csr_ctrl.sv
// Self-checking bench for csr_ctrl: directed scenarios plus random ops, scoreboarded against a
// behavioural CSR model; the bench also plays the role of the CSR read decoder.
module tb_csr_ctrl;
  localparam int unsigned N    = 64;
  localparam int unsigned NCSR = 6;
  localparam logic [63:0] MISA = 64'h8000_0000_0014_1101;

  logic                   clk = 1'b0;
  logic                   reset_n;
  logic                   csr_req, csr_src_zero, trap_req, mret_req;
  logic [2:0]             csr_op;
  logic [11:0]            csr_addr, csr_addr_q;
  logic [N-1:0]           csr_wdata, csr_read, csr_rdata, trap_cause, trap_pc, redirect_pc;
  logic [4:0]             csr_zimm;
  logic [NCSR-1:0][N-1:0] csr_out;
  logic                   csr_done, csr_illegal, redirect_valid, busy;

  csr_ctrl #(.N(N), .NCSR(NCSR)) dut (
    .clk(clk), .reset_n(reset_n), .csr_req(csr_req), .csr_op(csr_op), .csr_addr(csr_addr),
    .csr_wdata(csr_wdata), .csr_zimm(csr_zimm), .csr_src_zero(csr_src_zero),
    .csr_addr_q(csr_addr_q), .csr_read(csr_read), .csr_out(csr_out), .csr_rdata(csr_rdata),
    .csr_done(csr_done), .csr_illegal(csr_illegal), .trap_req(trap_req),
    .trap_cause(trap_cause), .trap_pc(trap_pc), .mret_req(mret_req),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .busy(busy)
  );

  always #5 clk = ~clk;

  // Read decoder environment
  always_comb begin
    case (csr_addr_q)
      12'h340: csr_read = csr_out[0];
      12'h300: csr_read = csr_out[1];
      12'h342: csr_read = csr_out[2];
      12'h305: csr_read = csr_out[3];
      12'h341: csr_read = csr_out[4];
      12'hC00: csr_read = csr_out[5];
      12'h301: csr_read = MISA;
      12'hF11, 12'hF12, 12'hF13, 12'hF14: csr_read = {52'b0, csr_addr_q};
      default: csr_read = '0;
    endcase
  end

  // Reference model state
  logic [63:0] m_mscratch, m_mstatus, m_mcause, m_mtvec, m_mepc, cyc_m;
  logic [64:0] sb_csr[$];
  logic [63:0] sb_redir[$];
  int n_checks = 0;
  int n_fail   = 0;

  always @(posedge clk or negedge reset_n)
    if (!reset_n) cyc_m <= 64'd0;
    else          cyc_m <= cyc_m + 64'd1;

  task automatic check(input string name, input logic [64:0] got, input logic [64:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic m_reset();
    m_mscratch = 0; m_mstatus = 64'h1800; m_mcause = 0; m_mtvec = 0; m_mepc = 0;
  endtask

  function automatic logic m_legal(input logic [11:0] a);
    case (a)
      12'h300, 12'h301, 12'h305, 12'h340, 12'h341, 12'h342,
      12'hC00, 12'hF11, 12'hF12, 12'hF13, 12'hF14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic m_ro(input logic [11:0] a);
    return a == 12'h301 || a == 12'hC00 || (a >= 12'hF11 && a <= 12'hF14);
  endfunction

  function automatic logic [63:0] m_read(input logic [11:0] a);
    case (a)
      12'h340: return m_mscratch;
      12'h300: return m_mstatus;
      12'h342: return m_mcause;
      12'h305: return m_mtvec;
      12'h341: return m_mepc;
      12'hC00: return cyc_m;
      12'h301: return MISA;
      12'hF11, 12'hF12, 12'hF13, 12'hF14: return {52'b0, a};
      default: return 64'd0;
    endcase
  endfunction

  task automatic m_write(input logic [11:0] a, input logic [63:0] v);
    case (a)
      12'h300: m_mstatus  = (v & 64'h88) | 64'h1800;
      12'h305: m_mtvec    = v & ~64'h2;
      12'h340: m_mscratch = v;
      12'h341: m_mepc     = v & ~64'h3;
      12'h342: m_mcause   = v;
      default: ;
    endcase
  endtask

  task automatic check_csrs(input string tag);
    check({tag, "_mscratch"}, {1'b0, csr_out[0]}, {1'b0, m_mscratch});
    check({tag, "_mstatus"},  {1'b0, csr_out[1]}, {1'b0, m_mstatus});
    check({tag, "_mcause"},   {1'b0, csr_out[2]}, {1'b0, m_mcause});
    check({tag, "_mtvec"},    {1'b0, csr_out[3]}, {1'b0, m_mtvec});
    check({tag, "_mepc"},     {1'b0, csr_out[4]}, {1'b0, m_mepc});
  endtask

  // Monitor: pops expected responses whenever the DUT presents one
  logic [64:0] exp_c;
  logic [63:0] exp_r;
  always @(negedge clk) begin
    if (reset_n) begin
      if (csr_done) begin
        if (sb_csr.size() == 0) check("csr_done_unexpected", 65'd1, 65'd0);
        else begin
          exp_c = sb_csr.pop_front();
          check("csr_resp", {csr_illegal, csr_rdata}, exp_c);
        end
      end
      if (redirect_valid) begin
        if (sb_redir.size() == 0) check("redirect_unexpected", 65'd1, 65'd0);
        else begin
          exp_r = sb_redir.pop_front();
          check("redirect_pc", {1'b0, redirect_pc}, {1'b0, exp_r});
        end
      end
    end
  end

  task automatic csr_setup(input logic [2:0] op, input logic [11:0] a, input logic [63:0] wd,
                           input logic [4:0] zi, input logic sz);
    csr_op = op; csr_addr = a; csr_wdata = wd; csr_zimm = zi; csr_src_zero = sz;
    csr_req = 1'b1;
  endtask

  // Called #1 after the accepting edge
  task automatic csr_accepted();
    logic [63:0] src, old, nv;
    logic        wr, ill;
    csr_req = 1'b0;
    src = csr_op[2] ? {59'b0, csr_zimm} : csr_wdata;
    old = m_read(csr_addr);
    wr  = (csr_op[1:0] == 2'b01) || !csr_src_zero;
    ill = !m_legal(csr_addr) || (m_ro(csr_addr) && wr);
    sb_csr.push_back(ill ? {1'b1, 64'd0} : {1'b0, old});
    if (!ill && wr) begin
      case (csr_op[1:0])
        2'b01:   nv = src;
        2'b10:   nv = old | src;
        default: nv = old & ~src;
      endcase
      m_write(csr_addr, nv);
    end
    check("busy_rd", {64'd0, busy}, 65'd1);
    check("done_early", {64'd0, csr_done}, 65'd0);
    @(posedge clk); #1;
    check("busy_wr", {64'd0, busy}, 65'd1);
    @(posedge clk); #1;
    check("busy_after_op", {64'd0, busy}, 65'd0);
    check("done_latency", {64'd0, csr_done}, 65'd1);
  endtask

  task automatic csr_go(input logic [2:0] op, input logic [11:0] a, input logic [63:0] wd,
                        input logic [4:0] zi, input logic sz);
    csr_setup(op, a, wd, zi, sz);
    @(posedge clk); #1;
    csr_accepted();
  endtask

  task automatic trap_accepted();
    logic [63:0] tgt;
    trap_req = 1'b0;
    tgt = m_mtvec & ~64'h3;
    if (m_mtvec[0] && trap_cause[63]) tgt = tgt + (trap_cause & ~(64'd1 << 63)) * 64'd4;
    sb_redir.push_back(tgt);
    m_mepc     = trap_pc & ~64'h3;
    m_mcause   = trap_cause;
    m_mstatus[7] = m_mstatus[3];
    m_mstatus[3] = 1'b0;
    check("busy_trap", {64'd0, busy}, 65'd1);
  endtask

  task automatic finish_redirect(input string tag);
    @(posedge clk); #1;
    check({tag, "_busy_after"}, {64'd0, busy}, 65'd0);
    check({tag, "_redirect_valid"}, {64'd0, redirect_valid}, 65'd1);
  endtask

  task automatic do_trap(input logic [63:0] cause, input logic [63:0] pc);
    trap_cause = cause; trap_pc = pc; trap_req = 1'b1;
    @(posedge clk); #1;
    trap_accepted();
    finish_redirect("trap");
  endtask

  task automatic do_mret();
    mret_req = 1'b1;
    @(posedge clk); #1;
    mret_req = 1'b0;
    sb_redir.push_back(m_mepc);
    m_mstatus[3] = m_mstatus[7];
    m_mstatus[7] = 1'b1;
    check("busy_mret", {64'd0, busy}, 65'd1);
    finish_redirect("mret");
  endtask

  initial begin
    logic [2:0]  ops   [6]  = '{3'b001, 3'b010, 3'b011, 3'b101, 3'b110, 3'b111};
    logic [11:0] addrs [13] = '{12'h300, 12'h301, 12'h305, 12'h340, 12'h341, 12'h342, 12'hC00,
                                12'hF11, 12'hF12, 12'hF13, 12'hF14, 12'h344, 12'h000};
    reset_n = 1'b0;
    csr_req = 0; csr_op = 0; csr_addr = 0; csr_wdata = 0; csr_zimm = 0; csr_src_zero = 0;
    trap_req = 0; trap_cause = 0; trap_pc = 0; mret_req = 0;
    m_reset();
    repeat (3) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    #1;
    check_csrs("reset");
    check("reset_cycle", {1'b0, csr_out[5]}, 65'd0);
    check("reset_addr_q", {53'd0, csr_addr_q}, 65'd0);
    check("reset_busy", {64'd0, busy}, 65'd0);
    check("reset_pulses", {62'd0, csr_done, csr_illegal, redirect_valid}, 65'd0);
    check("reset_rdata", {1'b0, csr_rdata}, 65'd0);
    @(posedge clk); #1;

    // Basic write, then mstatus masking and suppressed-write rule
    csr_go(3'b001, 12'h340, 64'hDEAD, 5'd0, 1'b0);
    check_csrs("rw_mscratch");
    csr_go(3'b001, 12'h300, 64'h1808, 5'd0, 1'b0);
    csr_go(3'b111, 12'h300, 64'd0, 5'd8, 1'b0);
    check_csrs("rci_mstatus");
    csr_go(3'b001, 12'h300, 64'hFFFF_FFFF_FFFF_FFFF, 5'd0, 1'b0);
    csr_go(3'b111, 12'h300, 64'd0, 5'd0, 1'b1);
    check_csrs("rci_zero");
    // Read-only addresses
    csr_go(3'b001, 12'h301, 64'h1234, 5'd0, 1'b0);
    csr_go(3'b010, 12'hC00, 64'd0, 5'd0, 1'b1);
    csr_go(3'b010, 12'hF13, 64'd0, 5'd0, 1'b1);
    csr_go(3'b001, 12'h7C0, 64'd5, 5'd0, 1'b0);
    check_csrs("ro");

    // Vectored trap then MRET
    csr_go(3'b001, 12'h305, 64'h1001, 5'd0, 1'b0);
    csr_go(3'b001, 12'h300, 64'h8, 5'd0, 1'b0);
    do_trap(64'h8000_0000_0000_0007, 64'h206);
    check_csrs("trap");
    do_mret();
    check_csrs("mret");

    // Trap and CSR request together: trap wins, CSR op follows
    csr_setup(3'b001, 12'h342, 64'h55, 5'd0, 1'b0);
    trap_cause = 64'd2; trap_pc = 64'h4000; trap_req = 1'b1;
    @(posedge clk); #1;
    trap_accepted();
    finish_redirect("trap_vs_csr");
    @(posedge clk); #1;
    csr_accepted();
    check_csrs("trap_then_csr");

    // Reset while in RD abandons the op
    csr_setup(3'b001, 12'h340, 64'hBAD, 5'd0, 1'b0);
    @(posedge clk); #1;
    csr_req = 1'b0;
    @(negedge clk) reset_n = 1'b0;
    m_reset();
    #1;
    check("rst_busy", {64'd0, busy}, 65'd0);
    @(negedge clk) reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_no_done", {64'd0, csr_done}, 65'd0);
    check_csrs("rst_mid");

    // Random mix
    for (int i = 0; i < 80; i++) begin
      int unsigned r;
      r = $urandom_range(0, 9);
      if (r <= 6) begin
        logic [2:0]  op;
        logic [4:0]  zi;
        logic [63:0] wd;
        logic        sz;
        op = ops[$urandom_range(0, 5)];
        zi = 5'($urandom_range(0, 31));
        wd = {$urandom, $urandom};
        if (op[2]) sz = (zi == 5'd0);
        else begin
          sz = ($urandom_range(0, 3) == 0);
          if (sz) wd = 64'd0;
        end
        csr_go(op, addrs[$urandom_range(0, 12)], wd, zi, sz);
      end else if (r == 7) begin
        do_trap({$urandom_range(0, 1) == 1, 59'd0, 4'($urandom_range(0, 15))},
                {$urandom, $urandom});
      end else begin
        do_mret();
      end
    end
    check_csrs("random_end");

    // cycle wrap
    @(negedge clk);
    force dut.cycle_q = 64'hFFFF_FFFF_FFFF_FFFE;
    #1 release dut.cycle_q;
    check("cycle_preload", {1'b0, csr_out[5]}, {1'b0, 64'hFFFF_FFFF_FFFF_FFFE});
    @(negedge clk);
    check("cycle_max", {1'b0, csr_out[5]}, {1'b0, 64'hFFFF_FFFF_FFFF_FFFF});
    @(negedge clk);
    check("cycle_wrap", {1'b0, csr_out[5]}, 65'd0);

    repeat (2) @(posedge clk);
    #1;
    check("sb_csr_drained", 65'(sb_csr.size()), 65'd0);
    check("sb_redir_drained", 65'(sb_redir.size()), 65'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
